axi_demux_addr_decode: RTL and testbench

//  Upstream stage of the crossbar demux core. Decodes AW/AR addresses against a rule table into

---
 rtl/axi_xbar_pkg.sv | 82 ++++++++
 rtl/axi_spill_slice.sv | 77 +++++++
 rtl/axi_demux_addr_decode.sv | 155 +++++++++++++++
 tb/tb_axi_demux_addr_decode.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_xbar_pkg.sv
// Shared types for the crossbar address-decode stage: address rules, AXI channel structs,
// spill-slice states and the miss-counter width.
package axi_xbar_pkg;

  localparam int unsigned AxiAddrWidth = 32;
  localparam int unsigned AxiDataWidth = 32;
  localparam int unsigned AxiIdWidth   = 4;
  localparam int unsigned MissCntWidth = 16;

  typedef struct packed {
    logic [31:0]             idx;
    logic [AxiAddrWidth-1:0] start_addr;
    logic [AxiAddrWidth-1:0] end_addr;
  } rule_t;

  typedef enum logic [1:0] {
    SpillEmpty = 2'd0,
    SpillOne   = 2'd1,
    SpillTwo   = 2'd2
  } spill_state_e;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiAddrWidth-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
  } aw_chan_t;

  typedef struct packed {
    logic [AxiDataWidth-1:0]   data;
    logic [AxiDataWidth/8-1:0] strb;
    logic                      last;
  } w_chan_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0] id;
    logic [1:0]            resp;
  } b_chan_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiAddrWidth-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
  } ar_chan_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiDataWidth-1:0] data;
    logic [1:0]              resp;
    logic                    last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    r_chan_t r;
    logic    r_valid;
  } axi_resp_t;

  // The error port sits just past the last mapped master port.
  function automatic int unsigned DefaultPortSel(input int unsigned noMstPorts);
    return noMstPorts;
  endfunction

endpackage

// File: rtl/axi_spill_slice.sv
// Two-entry FIFO spill slice with a registered upstream ready, so no combinational
// path exists from ready_i to ready_o.
module axi_spill_slice #(
  parameter type dtype = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic valid_i,
  output logic ready_o,
  input  dtype data_i,
  output logic valid_o,
  input  logic ready_i,
  output dtype data_o
);
  import axi_xbar_pkg::*;

  spill_state_e state_q;
  dtype         head_q;
  dtype         spare_q;
  logic         valid_q;
  logic         ready_q;
  logic         push;
  logic         pop;

  assign push = valid_i & ready_q;
  assign pop  = valid_q & ready_i;

  // head_q always holds the oldest beat; spare_q is only occupied in SpillTwo.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SpillEmpty;
      head_q  <= '0;
      spare_q <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      unique case (state_q)
        SpillEmpty: begin
          if (push) begin
            head_q  <= data_i;
            valid_q <= 1'b1;
            state_q <= SpillOne;
          end
        end
        SpillOne: begin
          if (push && pop) begin
            head_q <= data_i;
          end else if (push) begin
            spare_q <= data_i;
            ready_q <= 1'b0;
            state_q <= SpillTwo;
          end else if (pop) begin
            valid_q <= 1'b0;
            state_q <= SpillEmpty;
          end
        end
        SpillTwo: begin
          if (pop) begin
            head_q  <= spare_q;
            ready_q <= 1'b1;
            state_q <= SpillOne;
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= SpillEmpty;
        end
      endcase
    end
  end

  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign data_o  = head_q;

endmodule

// File: rtl/axi_demux_addr_decode.sv
// Address-decode front end of the crossbar demux: AW/AR get a port select and are spilled
// through two-entry slices; W/B/R pass straight through. Define AXI_DECODE_MISS_CNT_EN for miss counters.
module axi_demux_addr_decode #(
  parameter int unsigned NoMstPorts  = 32'd0,
  parameter int unsigned NoAddrRules = 32'd1,
  parameter int unsigned AddrWidth   = 32'd32,
  parameter type axi_req_t  = axi_xbar_pkg::axi_req_t,
  parameter type axi_resp_t = axi_xbar_pkg::axi_resp_t,
  parameter type rule_t     = axi_xbar_pkg::rule_t,
  parameter int unsigned SelectWidth = (NoMstPorts > 32'd0) ? $clog2(NoMstPorts + 1) : 32'd1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          test_i,
  input  rule_t [NoAddrRules-1:0]       addr_map_i,
  input  axi_req_t                      slv_req_i,
  output axi_resp_t                     slv_resp_o,
  output axi_req_t                      mst_req_o,
  input  axi_resp_t                     mst_resp_i,
  output logic [SelectWidth-1:0]        mst_aw_select_o,
  output logic [SelectWidth-1:0]        mst_ar_select_o
`ifdef AXI_DECODE_MISS_CNT_EN
  ,
  output logic [axi_xbar_pkg::MissCntWidth-1:0] aw_miss_cnt_o,
  output logic [axi_xbar_pkg::MissCntWidth-1:0] ar_miss_cnt_o
`endif
);
  import axi_xbar_pkg::*;

  typedef logic [SelectWidth-1:0] select_t;

  localparam select_t DefaultSel = select_t'(DefaultPortSel(NoMstPorts));

  typedef struct packed {
    select_t  sel;
    aw_chan_t chan;
  } aw_beat_t;

  typedef struct packed {
    select_t  sel;
    ar_chan_t chan;
  } ar_beat_t;

  // First matching rule wins; a winner pointing past the mapped ports still lands on the error port.
  function automatic select_t decodeAddr(input logic [AddrWidth-1:0] addr,
                                         input rule_t [NoAddrRules-1:0] addrMap);
    select_t sel;
    logic    hit;
    sel = DefaultSel;
    hit = 1'b0;
    for (int unsigned r = 0; r < NoAddrRules; r++) begin
      if (!hit && (addr >= AddrWidth'(addrMap[r].start_addr)) &&
          (addr < AddrWidth'(addrMap[r].end_addr))) begin
        hit = 1'b1;
        if (addrMap[r].idx < NoMstPorts) begin
          sel = select_t'(addrMap[r].idx);
        end
      end
    end
    return sel;
  endfunction

  aw_beat_t awBeatIn;
  aw_beat_t awBeatOut;
  ar_beat_t arBeatIn;
  ar_beat_t arBeatOut;
  logic     awReady;
  logic     awValid;
  logic     arReady;
  logic     arValid;
  logic     test_unused;

  assign test_unused = test_i;

  always_comb begin
    awBeatIn.sel  = decodeAddr(AddrWidth'(slv_req_i.aw.addr), addr_map_i);
    awBeatIn.chan = slv_req_i.aw;
    arBeatIn.sel  = decodeAddr(AddrWidth'(slv_req_i.ar.addr), addr_map_i);
    arBeatIn.chan = slv_req_i.ar;
  end

  axi_spill_slice #(
    .dtype (aw_beat_t)
  ) i_aw_slice (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (slv_req_i.aw_valid),
    .ready_o (awReady),
    .data_i  (awBeatIn),
    .valid_o (awValid),
    .ready_i (mst_resp_i.aw_ready),
    .data_o  (awBeatOut)
  );

  axi_spill_slice #(
    .dtype (ar_beat_t)
  ) i_ar_slice (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (slv_req_i.ar_valid),
    .ready_o (arReady),
    .data_i  (arBeatIn),
    .valid_o (arValid),
    .ready_i (mst_resp_i.ar_ready),
    .data_o  (arBeatOut)
  );

  always_comb begin
    mst_req_o          = slv_req_i;
    mst_req_o.aw       = awBeatOut.chan;
    mst_req_o.aw_valid = awValid;
    mst_req_o.ar       = arBeatOut.chan;
    mst_req_o.ar_valid = arValid;
    slv_resp_o          = mst_resp_i;
    slv_resp_o.aw_ready = awReady;
    slv_resp_o.ar_ready = arReady;
  end

  assign mst_aw_select_o = awBeatOut.sel;
  assign mst_ar_select_o = arBeatOut.sel;

`ifdef AXI_DECODE_MISS_CNT_EN
  logic [MissCntWidth-1:0] awMissCnt_q;
  logic [MissCntWidth-1:0] awMissCnt_d;
  logic [MissCntWidth-1:0] arMissCnt_q;
  logic [MissCntWidth-1:0] arMissCnt_d;
  logic                    awMiss;
  logic                    arMiss;

  assign awMiss = slv_req_i.aw_valid & awReady & (awBeatIn.sel == DefaultSel);
  assign arMiss = slv_req_i.ar_valid & arReady & (arBeatIn.sel == DefaultSel);

  // Counters saturate instead of wrapping so a stuck-high count stays visible.
  always_comb begin
    awMissCnt_d = awMissCnt_q;
    arMissCnt_d = arMissCnt_q;
    if (awMiss && (awMissCnt_q != '1)) awMissCnt_d = awMissCnt_q + MissCntWidth'(1);
    if (arMiss && (arMissCnt_q != '1)) arMissCnt_d = arMissCnt_q + MissCntWidth'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      awMissCnt_q <= '0;
      arMissCnt_q <= '0;
    end else begin
      awMissCnt_q <= awMissCnt_d;
      arMissCnt_q <= arMissCnt_d;
    end
  end

  assign aw_miss_cnt_o = awMissCnt_q;
  assign ar_miss_cnt_o = arMissCnt_q;
`endif

endmodule

// File: tb/tb_axi_demux_addr_decode.sv
// Directed bench for axi_demux_addr_decode: table-driven decode vectors plus hand-written
// spill-slice sequences (backpressure, streaming, reset while full).
module tb_axi_demux_addr_decode;
  import axi_xbar_pkg::*;

  localparam int unsigned NoMst   = 2;
  localparam int unsigned NoRules = 2;

  logic                  clk = 1'b0;
  logic                  rstN;
  logic                  testMode;
  rule_t [NoRules-1:0]   addrMap;
  axi_req_t              slvReq;
  axi_req_t              mstReq;
  axi_resp_t             slvResp;
  axi_resp_t             mstResp;
  logic [1:0]            awSel;
  logic [1:0]            arSel;
`ifdef AXI_DECODE_MISS_CNT_EN
  logic [15:0]           awMissCnt;
  logic [15:0]           arMissCnt;
`endif

  int testsRun    = 0;
  int testsFailed = 0;
  int expAwMiss   = 0;
  int expArMiss   = 0;

  typedef struct {
    rule_t [1:0] map;
    logic [31:0] addr;
    logic [1:0]  expSel;
  } vec_t;

  vec_t vecs[12];

  always #5 clk = ~clk;

  axi_demux_addr_decode #(
    .NoMstPorts  (NoMst),
    .NoAddrRules (NoRules),
    .AddrWidth   (32),
    .axi_req_t   (axi_req_t),
    .axi_resp_t  (axi_resp_t),
    .rule_t      (rule_t)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rstN),
    .test_i          (testMode),
    .addr_map_i      (addrMap),
    .slv_req_i       (slvReq),
    .slv_resp_o      (slvResp),
    .mst_req_o       (mstReq),
    .mst_resp_i      (mstResp),
    .mst_aw_select_o (awSel),
    .mst_ar_select_o (arSel)
`ifdef AXI_DECODE_MISS_CNT_EN
    ,
    .aw_miss_cnt_o   (awMissCnt),
    .ar_miss_cnt_o   (arMissCnt)
`endif
  );

  // Each check bumps the run count and reports any mismatch on one line.
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic awValid, input logic [31:0] awAddr,
                               input logic arValid, input logic [31:0] arAddr);
    slvReq.aw_valid = awValid;
    slvReq.aw.addr  = awAddr;
    slvReq.ar_valid = arValid;
    slvReq.ar.addr  = arAddr;
  endtask

  function automatic rule_t mkRule(input logic [31:0] idx, input logic [31:0] s, input logic [31:0] e);
    rule_t r;
    r.idx        = idx;
    r.start_addr = s;
    r.end_addr   = e;
    return r;
  endfunction

  // Watchdog so a wedged run still ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rule_t [1:0] baseMap;
    rule_t [1:0] overlapMap;
    rule_t [1:0] badIdxMap;
    rule_t [1:0] emptyMap;
    logic [31:0] addrK;

    baseMap[0]    = mkRule(32'd0, 32'h0000, 32'h1000);
    baseMap[1]    = mkRule(32'd1, 32'h1000, 32'h2000);
    overlapMap[0] = mkRule(32'd1, 32'h0000, 32'h2000);
    overlapMap[1] = mkRule(32'd0, 32'h1000, 32'h3000);
    badIdxMap[0]  = mkRule(32'd5, 32'h0000, 32'h1000);
    badIdxMap[1]  = mkRule(32'd1, 32'h1000, 32'h2000);
    emptyMap[0]   = mkRule(32'd0, 32'h1000, 32'h1000);
    emptyMap[1]   = mkRule(32'd1, 32'h0800, 32'h2000);

    vecs[0]  = '{baseMap,    32'h0000_0000, 2'd0};
    vecs[1]  = '{baseMap,    32'h0000_0FFF, 2'd0};
    vecs[2]  = '{baseMap,    32'h0000_1000, 2'd1};
    vecs[3]  = '{baseMap,    32'h0000_1004, 2'd1};
    vecs[4]  = '{baseMap,    32'h0000_1FFF, 2'd1};
    vecs[5]  = '{baseMap,    32'h0000_2000, 2'd2};
    vecs[6]  = '{baseMap,    32'h0000_3000, 2'd2};
    vecs[7]  = '{baseMap,    32'hFFFF_FFFF, 2'd2};
    vecs[8]  = '{overlapMap, 32'h0000_1800, 2'd1};
    vecs[9]  = '{overlapMap, 32'h0000_2800, 2'd0};
    vecs[10] = '{badIdxMap,  32'h0000_0010, 2'd2};
    vecs[11] = '{emptyMap,   32'h0000_1000, 2'd1};

    testMode = 1'b0;
    addrMap  = baseMap;
    slvReq   = '0;
    mstResp  = '0;
    mstResp.aw_ready = 1'b1;
    mstResp.ar_ready = 1'b1;
    rstN = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("reset_aw_valid", mstReq.aw_valid, 1'b0);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_aw_ready", slvResp.aw_ready, 1'b1);
    checkOutput("post_reset_ar_ready", slvResp.ar_ready, 1'b1);
    checkOutput("post_reset_ar_valid", mstReq.ar_valid, 1'b0);
    checkOutput("post_reset_aw_sel", awSel, 2'd0);
    checkOutput("post_reset_ar_sel", arSel, 2'd0);

    // W/B/R are combinational pass-throughs.
    slvReq.w.data   = 32'hDEAD_BEEF;
    slvReq.w_valid  = 1'b1;
    mstResp.r.data  = 32'hCAFE_F00D;
    mstResp.b.resp  = 2'b10;
    #1;
    checkOutput("w_passthrough", mstReq.w.data, 32'hDEAD_BEEF);
    checkOutput("w_valid_passthrough", mstReq.w_valid, 1'b1);
    checkOutput("r_passthrough", slvResp.r.data, 32'hCAFE_F00D);
    checkOutput("b_passthrough", slvResp.b.resp, 2'b10);
    slvReq.w_valid = 1'b0;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      addrMap = vecs[i].map;
      applyStimulus(1'b1, vecs[i].addr, 1'b1, vecs[i].addr);
      checkOutput($sformatf("vec%0d_aw_ready", i), slvResp.aw_ready, 1'b1);
      @(negedge clk);
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput($sformatf("vec%0d_aw_valid", i), mstReq.aw_valid, 1'b1);
      checkOutput($sformatf("vec%0d_aw_addr", i), mstReq.aw.addr, vecs[i].addr);
      checkOutput($sformatf("vec%0d_aw_sel", i), awSel, vecs[i].expSel);
      checkOutput($sformatf("vec%0d_ar_sel", i), arSel, vecs[i].expSel);
      if (vecs[i].expSel == 2'd2) begin
        expAwMiss++;
        expArMiss++;
      end
    end

    // Backpressure: three AW beats against a stalled master, only two fit.
    @(negedge clk);
    addrMap = baseMap;
    mstResp.aw_ready = 1'b0;
    applyStimulus(1'b1, 32'h0000_0010, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("bp_ready_one", slvResp.aw_ready, 1'b1);
    checkOutput("bp_head_a_first", mstReq.aw.addr, 32'h0000_0010);
    slvReq.aw.addr = 32'h0000_1010;
    @(negedge clk);
    checkOutput("bp_ready_two", slvResp.aw_ready, 1'b0);
    checkOutput("bp_head_a", mstReq.aw.addr, 32'h0000_0010);
    slvReq.aw.addr = 32'h0000_5000;
    @(negedge clk);
    checkOutput("bp_ready_still_low", slvResp.aw_ready, 1'b0);
    checkOutput("bp_head_a_stable", mstReq.aw.addr, 32'h0000_0010);
    checkOutput("bp_sel_a_stable", awSel, 2'd0);
    mstResp.aw_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_head_b", mstReq.aw.addr, 32'h0000_1010);
    checkOutput("bp_sel_b", awSel, 2'd1);
    checkOutput("bp_ready_release", slvResp.aw_ready, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    expAwMiss++;
    checkOutput("bp_head_c", mstReq.aw.addr, 32'h0000_5000);
    checkOutput("bp_sel_c", awSel, 2'd2);
    checkOutput("bp_valid_c", mstReq.aw_valid, 1'b1);
    @(negedge clk);
    checkOutput("bp_drained", mstReq.aw_valid, 1'b0);

    // Streaming AR: one beat per cycle, no bubbles, order kept.
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      if (k > 0) begin
        addrK = 32'h800 + 32'(k - 1) * 32'h100;
        checkOutput($sformatf("stream%0d_valid", k - 1), mstReq.ar_valid, 1'b1);
        checkOutput($sformatf("stream%0d_addr", k - 1), mstReq.ar.addr, addrK);
        checkOutput($sformatf("stream%0d_sel", k - 1), arSel, (addrK >= 32'h1000) ? 2'd1 : 2'd0);
        checkOutput($sformatf("stream%0d_ready", k - 1), slvResp.ar_ready, 1'b1);
      end
      if (k < 10) applyStimulus(1'b0, 32'h0, 1'b1, 32'h800 + 32'(k) * 32'h100);
      else        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    end
    @(negedge clk);
    checkOutput("stream_drained", mstReq.ar_valid, 1'b0);

`ifdef AXI_DECODE_MISS_CNT_EN
    checkOutput("aw_miss_cnt", awMissCnt, 16'(expAwMiss));
    checkOutput("ar_miss_cnt", arMissCnt, 16'(expArMiss));
`else
    $display("[TB] miss counters not built; model counts aw=%0d ar=%0d", expAwMiss, expArMiss);
`endif

    // Reset while the AW slice is full discards both beats.
    mstResp.aw_ready = 1'b0;
    applyStimulus(1'b1, 32'h0000_1100, 1'b0, 32'h0);
    @(negedge clk);
    slvReq.aw.addr = 32'h0000_1200;
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("rst_full_ready", slvResp.aw_ready, 1'b0);
    checkOutput("rst_full_valid", mstReq.aw_valid, 1'b1);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("rst_async_aw_valid", mstReq.aw_valid, 1'b0);
    checkOutput("rst_async_ar_valid", mstReq.ar_valid, 1'b0);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("rst_release_ready", slvResp.aw_ready, 1'b1);
    checkOutput("rst_release_sel", awSel, 2'd0);
    mstResp.aw_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checkOutput($sformatf("rst_no_replay%0d", n), mstReq.aw_valid, 1'b0);
    end
`ifdef AXI_DECODE_MISS_CNT_EN
    checkOutput("rst_miss_cnt", awMissCnt, 16'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
